// File: rtl/fetch_sequencer.sv
// Single-issue instruction fetch sequencer: fetch, deliver, resolve, next PC.
// Ports: clock/reset_n, run/halt control, imem req/addr/ack/rdata,
//   instr/instr_valid/instr_ready to decoder, resolve_valid with
//   branch/zero/jump qualifiers, pc, retire_count, state.
module fetch_sequencer #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
   input  logic        clock,
   input  logic        reset_n,
   input  logic        run,
   input  logic        halt,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   input  logic        imem_ack,
   input  logic [31:0] imem_rdata,
   output logic [31:0] instr,
   output logic        instr_valid,
   input  logic        instr_ready,
   input  logic        resolve_valid,
   input  logic        branch_control,
   input  logic        alu_zero_control,
   input  logic        jump_control,
   output logic [31:0] pc,
   output logic [31:0] retire_count,
   output logic [2:0]  state
);

   typedef enum logic [2:0] {
      S_IDLE    = 3'd0,
      S_FETCH   = 3'd1,
      S_DELIVER = 3'd2,
      S_RESOLVE = 3'd3,
      S_HALTED  = 3'd4
   } state_t;

   state_t cur, nxt;

   logic        fetch_done;
   logic        deliver_done;
   logic        resolve_done;
   logic [31:0] pcplus4;
   logic [31:0] br_off;
   logic [31:0] next_pc;

   assign fetch_done   = (cur == S_FETCH) && imem_ack;
   assign deliver_done = (cur == S_DELIVER) && instr_ready;
   assign resolve_done = (cur == S_RESOLVE) && resolve_valid;

   assign pcplus4 = pc + 32'd4;
   assign br_off  = {{14{instr[15]}}, instr[15:0], 2'b00};

   // Jump wins over a taken branch.
   always_comb begin
      next_pc = pcplus4;
      if (jump_control)
         next_pc = {pcplus4[31:28], instr[25:0], 2'b00};
      else if (branch_control && alu_zero_control)
         next_pc = pcplus4 + br_off;
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n)
         cur <= S_IDLE;
      else
         cur <= nxt;
   end

   always_comb begin
      nxt = cur;
      unique case (cur)
         S_IDLE:    if (run) nxt = S_FETCH;
         S_FETCH:   if (imem_ack) nxt = S_DELIVER;
         S_DELIVER: if (instr_ready) nxt = S_RESOLVE;
         S_RESOLVE: begin
            if (resolve_valid)
               nxt = halt ? S_HALTED : S_FETCH;
         end
         S_HALTED:  if (run) nxt = S_FETCH;
         default:   nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         pc           <= RESET_PC;
         instr        <= 32'd0;
         instr_valid  <= 1'b0;
         retire_count <= 32'd0;
      end else begin
         if (fetch_done) begin
            instr       <= imem_rdata;
            instr_valid <= 1'b1;
         end
         if (deliver_done)
            instr_valid <= 1'b0;
         if (resolve_done) begin
            pc           <= next_pc;
            retire_count <= retire_count + 32'd1;
         end
      end
   end

   assign imem_req  = (cur == S_FETCH);
   assign imem_addr = pc;
   assign state     = cur;

endmodule

// File: tb/tb_fetch_sequencer.sv
// Directed bench for fetch_sequencer.
// Inputs driven and outputs sampled on the falling clock edge.
module tb_fetch_sequencer;

   logic        clock;
   logic        reset_n;
   logic        run;
   logic        halt;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_ack;
   logic [31:0] imem_rdata;
   logic [31:0] instr;
   logic        instr_valid;
   logic        instr_ready;
   logic        resolve_valid;
   logic        branch_control;
   logic        alu_zero_control;
   logic        jump_control;
   logic [31:0] pc;
   logic [31:0] retire_count;
   logic [2:0]  state;

   int vectors;
   int miscompares;
   logic [31:0] exp_rc;

   fetch_sequencer #(.RESET_PC(32'h0000_0000)) dut (
      .clock            (clock),
      .reset_n          (reset_n),
      .run              (run),
      .halt             (halt),
      .imem_req         (imem_req),
      .imem_addr        (imem_addr),
      .imem_ack         (imem_ack),
      .imem_rdata       (imem_rdata),
      .instr            (instr),
      .instr_valid      (instr_valid),
      .instr_ready      (instr_ready),
      .resolve_valid    (resolve_valid),
      .branch_control   (branch_control),
      .alu_zero_control (alu_zero_control),
      .jump_control     (jump_control),
      .pc               (pc),
      .retire_count     (retire_count),
      .state            (state)
   );

   initial begin
      clock = 1'b0;
      forever #5 clock = ~clock;
   end

   // Stimulus only: one instruction from FETCH through resolve.
   task automatic issue(input logic [31:0] w, input logic j,
                        input logic b, input logic z, input logic h);
      imem_ack   = 1'b1;
      imem_rdata = w;
      @(negedge clock);
      imem_ack    = 1'b0;
      instr_ready = 1'b1;
      @(negedge clock);
      instr_ready      = 1'b0;
      resolve_valid    = 1'b1;
      jump_control     = j;
      branch_control   = b;
      alu_zero_control = z;
      halt             = h;
      @(negedge clock);
      resolve_valid    = 1'b0;
      jump_control     = 1'b0;
      branch_control   = 1'b0;
      alu_zero_control = 1'b0;
      halt             = 1'b0;
      exp_rc           = exp_rc + 32'd1;
   endtask

   task automatic test_reset();
      reset_n = 1'b0;
      #12;
      vectors++;
      if (state !== 3'd0) begin
         miscompares++;
         $display("FAIL rst_state: got %0d want 0", state);
      end
      vectors++;
      if (pc !== 32'h0) begin
         miscompares++;
         $display("FAIL rst_pc: got %h want 0", pc);
      end
      vectors++;
      if (imem_req !== 1'b0 || instr_valid !== 1'b0) begin
         miscompares++;
         $display("FAIL rst_req_valid: got %b%b want 00",
                  imem_req, instr_valid);
      end
      vectors++;
      if (instr !== 32'h0 || retire_count !== 32'h0) begin
         miscompares++;
         $display("FAIL rst_instr_rc: got %h %h want 0 0",
                  instr, retire_count);
      end
      @(negedge clock);
      reset_n = 1'b1;
      @(negedge clock);
      vectors++;
      if (state !== 3'd0) begin
         miscompares++;
         $display("FAIL idle_hold: got %0d want 0", state);
      end
   endtask

   task automatic test_sequential();
      logic [31:0] ep;
      logic [31:0] w;
      run = 1'b1;
      @(negedge clock);
      run = 1'b0;
      for (int i = 0; i < 3; i++) begin
         ep = 32'(i) * 32'd4;
         w  = 32'hA000_0000 | 32'(i);
         vectors++;
         if (state !== 3'd1 || imem_req !== 1'b1) begin
            miscompares++;
            $display("FAIL seq_fetch%0d: got st=%0d req=%b want 1 1",
                     i, state, imem_req);
         end
         vectors++;
         if (pc !== ep || imem_addr !== ep) begin
            miscompares++;
            $display("FAIL seq_pc%0d: got %h/%h want %h",
                     i, pc, imem_addr, ep);
         end
         imem_ack   = 1'b1;
         imem_rdata = w;
         @(negedge clock);
         imem_ack = 1'b0;
         vectors++;
         if (state !== 3'd2 || instr !== w || instr_valid !== 1'b1
             || imem_req !== 1'b0) begin
            miscompares++;
            $display("FAIL seq_deliver%0d: got st=%0d i=%h v=%b r=%b want 2 %h 1 0",
                     i, state, instr, instr_valid, imem_req, w);
         end
         instr_ready = 1'b1;
         @(negedge clock);
         instr_ready = 1'b0;
         vectors++;
         if (state !== 3'd3 || instr_valid !== 1'b0
             || retire_count !== exp_rc) begin
            miscompares++;
            $display("FAIL seq_resolve%0d: got st=%0d v=%b rc=%0d want 3 0 %0d",
                     i, state, instr_valid, retire_count, exp_rc);
         end
         resolve_valid = 1'b1;
         @(negedge clock);
         resolve_valid = 1'b0;
         exp_rc = exp_rc + 32'd1;
         vectors++;
         if (retire_count !== exp_rc || pc !== ep + 32'd4) begin
            miscompares++;
            $display("FAIL seq_retire%0d: got rc=%0d pc=%h want %0d %h",
                     i, retire_count, pc, exp_rc, ep + 32'd4);
         end
      end
   endtask

   task automatic test_branch();
      issue(32'h0000_0040, 1'b1, 1'b0, 1'b0, 1'b0);
      vectors++;
      if (pc !== 32'h100) begin
         miscompares++;
         $display("FAIL br_setup: got %h want 00000100", pc);
      end
      issue(32'h0000_FFFE, 1'b0, 1'b1, 1'b1, 1'b0);
      vectors++;
      if (pc !== 32'h0FC) begin
         miscompares++;
         $display("FAIL br_taken: got %h want 000000fc", pc);
      end
      issue(32'h0000_0040, 1'b1, 1'b0, 1'b0, 1'b0);
      issue(32'h0000_FFFE, 1'b0, 1'b1, 1'b0, 1'b0);
      vectors++;
      if (pc !== 32'h104) begin
         miscompares++;
         $display("FAIL br_not_taken: got %h want 00000104", pc);
      end
      vectors++;
      if (retire_count !== exp_rc) begin
         miscompares++;
         $display("FAIL br_rc: got %0d want %0d", retire_count, exp_rc);
      end
   endtask

   task automatic test_backpressure();
      resolve_valid = 1'b1;
      halt          = 1'b1;
      for (int i = 0; i < 4; i++) begin
         vectors++;
         if (state !== 3'd1 || imem_req !== 1'b1
             || imem_addr !== 32'h104) begin
            miscompares++;
            $display("FAIL bp_fetch%0d: got st=%0d r=%b a=%h want 1 1 00000104",
                     i, state, imem_req, imem_addr);
         end
         if (i == 3) begin
            imem_ack   = 1'b1;
            imem_rdata = 32'h1234_5678;
         end
         @(negedge clock);
      end
      imem_rdata = 32'hDEAD_BEEF;
      for (int i = 0; i < 2; i++) begin
         vectors++;
         if (state !== 3'd2 || instr !== 32'h1234_5678
             || instr_valid !== 1'b1 || retire_count !== exp_rc) begin
            miscompares++;
            $display("FAIL bp_deliver%0d: got st=%0d i=%h v=%b rc=%0d want 2 12345678 1 %0d",
                     i, state, instr, instr_valid, retire_count, exp_rc);
         end
         @(negedge clock);
      end
      imem_ack      = 1'b0;
      resolve_valid = 1'b0;
      halt          = 1'b0;
      instr_ready   = 1'b1;
      @(negedge clock);
      instr_ready = 1'b0;
      vectors++;
      if (state !== 3'd3 || instr_valid !== 1'b0
          || instr !== 32'h1234_5678 || retire_count !== exp_rc) begin
         miscompares++;
         $display("FAIL bp_resolve: got st=%0d v=%b i=%h rc=%0d want 3 0 12345678 %0d",
                  state, instr_valid, instr, retire_count, exp_rc);
      end
      resolve_valid = 1'b1;
      @(negedge clock);
      exp_rc = exp_rc + 32'd1;
      @(negedge clock);
      resolve_valid = 1'b0;
      vectors++;
      if (state !== 3'd1 || retire_count !== exp_rc
          || pc !== 32'h108) begin
         miscompares++;
         $display("FAIL bp_single_count: got st=%0d rc=%0d pc=%h want 1 %0d 00000108",
                  state, retire_count, pc, exp_rc);
      end
   endtask

   task automatic test_halt();
      issue(32'h0000_0008, 1'b1, 1'b0, 1'b0, 1'b0);
      vectors++;
      if (pc !== 32'h20) begin
         miscompares++;
         $display("FAIL halt_setup: got %h want 00000020", pc);
      end
      issue(32'h0000_0000, 1'b0, 1'b0, 1'b0, 1'b1);
      vectors++;
      if (state !== 3'd4 || pc !== 32'h24 || imem_req !== 1'b0
          || instr_valid !== 1'b0) begin
         miscompares++;
         $display("FAIL halt_enter: got st=%0d pc=%h r=%b v=%b want 4 00000024 0 0",
                  state, pc, imem_req, instr_valid);
      end
      @(negedge clock);
      @(negedge clock);
      vectors++;
      if (state !== 3'd4) begin
         miscompares++;
         $display("FAIL halt_stay: got %0d want 4", state);
      end
      run = 1'b1;
      @(negedge clock);
      run = 1'b0;
      vectors++;
      if (state !== 3'd1 || imem_req !== 1'b1
          || imem_addr !== 32'h24) begin
         miscompares++;
         $display("FAIL halt_resume: got st=%0d r=%b a=%h want 1 1 00000024",
                  state, imem_req, imem_addr);
      end
   endtask

   task automatic test_jump_wrap();
      logic [31:0] ep;
      for (int k = 0; k < 8; k++) begin
         issue(32'h03FF_FFFF, 1'b1, 1'b0, 1'b0, 1'b0);
         ep = {k[3:0], 28'hFFF_FFFC};
         vectors++;
         if (pc !== ep) begin
            miscompares++;
            $display("FAIL climb%0d: got %h want %h", k, pc, ep);
         end
      end
      issue(32'h0000_0004, 1'b1, 1'b0, 1'b0, 1'b0);
      vectors++;
      if (pc !== 32'h8000_0010) begin
         miscompares++;
         $display("FAIL jp_setup: got %h want 80000010", pc);
      end
      issue(32'h0000_0040, 1'b1, 1'b1, 1'b1, 1'b0);
      vectors++;
      if (pc !== 32'h8000_0100) begin
         miscompares++;
         $display("FAIL jump_priority: got %h want 80000100", pc);
      end
      for (int k = 8; k < 16; k++) begin
         issue(32'h03FF_FFFF, 1'b1, 1'b0, 1'b0, 1'b0);
         ep = {k[3:0], 28'hFFF_FFFC};
         vectors++;
         if (pc !== ep) begin
            miscompares++;
            $display("FAIL climb%0d: got %h want %h", k, pc, ep);
         end
      end
      issue(32'h0000_0000, 1'b0, 1'b0, 1'b0, 1'b0);
      vectors++;
      if (pc !== 32'h0 || state !== 3'd1) begin
         miscompares++;
         $display("FAIL pc_wrap: got pc=%h st=%0d want 00000000 1",
                  pc, state);
      end
      vectors++;
      if (retire_count !== exp_rc) begin
         miscompares++;
         $display("FAIL wrap_rc: got %0d want %0d", retire_count, exp_rc);
      end
   endtask

   task automatic test_reset_mid();
      imem_ack   = 1'b1;
      imem_rdata = 32'hCAFE_F00D;
      @(negedge clock);
      imem_ack = 1'b0;
      vectors++;
      if (state !== 3'd2 || instr !== 32'hCAFE_F00D) begin
         miscompares++;
         $display("FAIL mid_setup: got st=%0d i=%h want 2 cafef00d",
                  state, instr);
      end
      #2 reset_n = 1'b0;
      #1;
      vectors++;
      if (state !== 3'd0 || instr !== 32'h0 || instr_valid !== 1'b0
          || imem_req !== 1'b0) begin
         miscompares++;
         $display("FAIL async_rst: got st=%0d i=%h v=%b r=%b want 0 0 0 0",
                  state, instr, instr_valid, imem_req);
      end
      vectors++;
      if (pc !== 32'h0 || retire_count !== 32'h0) begin
         miscompares++;
         $display("FAIL async_rst_pc: got %h %h want 0 0",
                  pc, retire_count);
      end
      @(negedge clock);
      reset_n       = 1'b1;
      imem_ack      = 1'b1;
      imem_rdata    = 32'h1111_1111;
      instr_ready   = 1'b1;
      resolve_valid = 1'b1;
      @(negedge clock);
      imem_ack      = 1'b0;
      instr_ready   = 1'b0;
      resolve_valid = 1'b0;
      vectors++;
      if (state !== 3'd0 || instr !== 32'h0 || instr_valid !== 1'b0
          || imem_req !== 1'b0) begin
         miscompares++;
         $display("FAIL late_ack: got st=%0d i=%h v=%b r=%b want 0 0 0 0",
                  state, instr, instr_valid, imem_req);
      end
      vectors++;
      if (pc !== 32'h0 || retire_count !== 32'h0) begin
         miscompares++;
         $display("FAIL late_ack_pc: got %h %h want 0 0",
                  pc, retire_count);
      end
   endtask

   initial begin
      vectors          = 0;
      miscompares      = 0;
      exp_rc           = 32'd0;
      reset_n          = 1'b0;
      run              = 1'b0;
      halt             = 1'b0;
      imem_ack         = 1'b0;
      imem_rdata       = 32'd0;
      instr_ready      = 1'b0;
      resolve_valid    = 1'b0;
      branch_control   = 1'b0;
      alu_zero_control = 1'b0;
      jump_control     = 1'b0;
      test_reset();
      test_sequential();
      test_branch();
      test_backpressure();
      test_halt();
      test_jump_wrap();
      test_reset_mid();
      $display("== %0d vectors applied, %0d miscompares ==",
               vectors, miscompares);
      $finish;
   end

endmodule
